swim_seq_tx: RTL
================

# swim_seq_tx

Parametrised open-drain pulse-sequence engine for the SWIM debug line. It generalises the fixed 36-bit SWIM entry sequencer: pattern, length and bit period are supplied per command over a valid/ready handshake. The line level is sampled mid-bit and the result is returned on a response channel, so the USB-UART command path can both send SWIM sequences and observe device pull-downs. It sits between the command FIFO in `top` and the SB_IO tristate cell on the `swim` pin.

## Interface
- `MAX_BITS`, 64: maximum pattern length in bits.
- `DIV_WIDTH`, 14: width of the bit-period field.
- `LEN_WIDTH`, $clog2(MAX_BITS+1): width of the length field.
- `clk`  in  1  system clock, 48 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_pattern`  in  MAX_BITS  bit i = level of bit i; sent MSB-first from bit `len`-1.
- `cmd_len`  in  LEN_WIDTH  number of bits; values above MAX_BITS clamp to MAX_BITS.
- `cmd_div`  in  DIV_WIDTH  bit period in clk cycles; 0 is treated as 1.
- `abort`  in  1  single-cycle pulse that cancels the active command.
- `swim_oe`  out  1  1 = drive line low; the SB_IO D_OUT is tied 0 at top level.
- `swim_in`  in  1  raw pad input, asynchronous.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  MAX_BITS  sampled line level per sent bit; unsent bits are 0.
- `busy`  out  1  high in SEND or RESP.

## Operation
- States:
  - IDLE → SEND on `cmd_valid & cmd_ready` when len > 0.
  - IDLE → RESP on the same handshake when len == 0.
  - SEND → RESP after the last bit.
  - RESP → IDLE on `rsp_valid & rsp_ready`.
  - SEND → IDLE on `abort` (no response is produced).
- On accept, latch pattern, clamped len, effective period P and bit index = len-1, and clear `rsp_data`.
- In SEND, `swim_oe` = ~pattern[index]: a 0 bit drives low, a 1 bit releases.
- `swim_in` passes through a 2-flop synchroniser; the synchronised value is written to `rsp_data[index]` when the period counter equals P>>1.
- At the end of each period the index decrements. The transition to RESP happens on the end of the period where index==0.
- In IDLE and RESP, `swim_oe` = 0 (line released).
- `abort` is ignored in IDLE and RESP.
- `abort` coincident with the last bit's end wins: the block goes to IDLE and no response is produced.
- Asynchronous `reset` at any point:
  - outputs and state return to their reset values immediately;
  - the line is released;
  - pending command and response are discarded.

## Timing
- Reset values: `cmd_ready`=1, `swim_oe`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, state IDLE, synchroniser flops 1.
- Accept at cycle T:
  - bit k (k=0 is the first sent) drives `swim_oe` during cycles T+1+k·P through T+(k+1)·P;
  - `rsp_valid`=1 and `swim_oe`=0 from cycle T+1+len·P.
- len==0: `rsp_valid`=1 at T+1; `swim_oe` is never asserted.
- Sample point of bit k is cycle T+1+k·P+(P>>1). The sampled value reflects the pad 2 cycles earlier.
- `rsp_data` is stable while `rsp_valid`=1 and `rsp_ready`=0.
- `cmd_ready` returns high the cycle after the response handshake. No back-to-back accept occurs on the handshake cycle itself.
- Period counter width is DIV_WIDTH; counting is 0..P-1 with no wrap beyond P-1.
- Legacy SWIM entry: pattern 0xFF3333557, len 36, div 12000 (250 µs per bit).

## Structure
- Package `swim_pkg`:
  - state enum {IDLE, SEND, RESP};
  - constant `SWIM_DIV_DEFAULT` = 12000;
  - constant `SWIM_ENTRY_PATTERN` = 36'hFF3333557;
  - constant `SWIM_ENTRY_LEN` = 36.
- Sub-module `swim_bit_timer`: programmable-period counter with a start/clear input, emitting `mid` and `end` strobes. It replaces the fixed `clk_div`.
- The SB_IO instance stays at top level; this block is pure logic.

## Test plan
- **Reset values:** assert `reset` for 3 cycles → `cmd_ready`=1, `swim_oe`=0, `rsp_valid`=0, `busy`=0.
- **Loopback, 8 bits:** pattern 0xA6, len 8, div 4, `swim_in`=~`swim_oe`.
  - `swim_oe` sequence 0,1,0,1,1,0,0,1, 4 cycles each.
  - `rsp_valid` at T+33; `rsp_data`=0xA6.
- **Device holds line low:** all-ones pattern, len 4, div 6, `swim_in`=0 throughout → `swim_oe` stays 0; `rsp_data`=0x0.
- **Zero length:** len 0 → `rsp_valid` at T+1, `rsp_data`=0, `swim_oe` never 1.
- **Response backpressure:** hold `rsp_ready`=0 for 10 cycles.
  - `rsp_valid` and `rsp_data` stay stable; `cmd_ready` stays 0.
  - A pending command is accepted on the cycle after the handshake.
- **Abort and reset mid-bit:** `abort` during bit 3 of a 36-bit entry sequence → `swim_oe`=0 next cycle, no `rsp_valid`, `cmd_ready`=1. Repeat with async `reset` instead of `abort` → `swim_oe`=0 in the same cycle.

Source files
------------

// File: rtl/swim_pkg.sv
// Shared types and constants for the SWIM pulse-sequence engine.
package swim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int SWIM_DIV_DEFAULT = 12000;
  localparam logic [35:0] SWIM_ENTRY_PATTERN = 36'hFF3333557;
  localparam int SWIM_ENTRY_LEN = 36;

endpackage

// File: rtl/swim_bit_timer.sv
// Programmable bit-period counter with mid-bit and end-of-bit strobes.
module swim_bit_timer #(
  parameter int DIV_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 mid_stb,
  output logic                 end_stb
);

  logic [DIV_WIDTH-1:0] cnt;

  // >= keeps the count bounded even if period shrinks mid-flight
  assign mid_stb = !clear && (cnt == (period >> 1));
  assign end_stb = !clear && (cnt >= period - DIV_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || end_stb) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/swim_seq_tx.sv
// Open-drain SWIM pulse-sequence engine with mid-bit line sampling.
module swim_seq_tx
  import swim_pkg::*;
#(
  parameter int MAX_BITS  = 64,
  parameter int DIV_WIDTH = 14,
  parameter int LEN_WIDTH = $clog2(MAX_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [MAX_BITS-1:0]  cmd_pattern,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic [DIV_WIDTH-1:0] cmd_div,
  input  logic                 abort,
  output logic                 swim_oe,
  input  logic                 swim_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MAX_BITS-1:0]  rsp_data,
  output logic                 busy
);

  localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  state_t               state;
  state_t               state_nxt;
  logic [MAX_BITS-1:0]  pat_q;
  logic [MAX_BITS-1:0]  data_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DIV_WIDTH-1:0] per_q;
  logic                 sync1;
  logic                 sync2;
  logic                 accept;
  logic                 mid_stb;
  logic                 end_stb;
  logic [LEN_WIDTH-1:0] len_c;
  logic [DIV_WIDTH-1:0] div_c;

  assign accept = cmd_valid && (state == IDLE);

  assign len_c = (cmd_len > LEN_WIDTH'(MAX_BITS))
               ? LEN_WIDTH'(MAX_BITS) : cmd_len;
  assign div_c = (cmd_div == '0) ? DIV_WIDTH'(1) : cmd_div;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state == SEND) || (state == RESP);
  assign rsp_data  = data_q;

  // Combinational so an async reset releases the line immediately
  assign swim_oe = (state == SEND) && !pat_q[idx_q];

  swim_bit_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != SEND),
    .period  (per_q),
    .mid_stb (mid_stb),
    .end_stb (end_stb)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (len_c == '0) ? RESP : SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (end_stb && idx_q == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= swim_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= '0;
      data_q <= '0;
      idx_q  <= '0;
      per_q  <= DIV_WIDTH'(1);
    end else if (accept) begin
      pat_q  <= cmd_pattern;
      data_q <= '0;
      per_q  <= div_c;
      idx_q  <= (len_c == '0) ? '0
              : IDX_W'(len_c - LEN_WIDTH'(1));
    end else if (state == SEND) begin
      if (mid_stb) begin
        data_q[idx_q] <= sync2;
      end
      if (end_stb && idx_q != '0) begin
        idx_q <= idx_q - IDX_W'(1);
      end
    end
  end

endmodule
